// File: rtl/miriscv_data_arbiter.sv
// ----------------------------------------------------------------------------
// miriscv_data_arbiter
//
// Shares the single data-memory port of the miriscv core between the LSU
// (master 0) and a second bus master (master 1, e.g. loader or debug/DMA).
// Round-robin arbitration, one transaction per cycle, and a fixed one-cycle
// memory read latency tracked by a registered response tag.
//
// Ports:
//   clk_i, arst_i              clock, asynchronous active-high reset
//   mX_req_i/we_i/be_i/        request and payload from master X (X = 0, 1)
//   mX_addr_i/wdata_i
//   mX_gnt_o                   request of master X accepted this cycle
//   mX_rvalid_o, mX_rdata_o    response for master X's previously granted
//                              transaction (read data, or write acknowledge)
//   data_req_o/we_o/be_o/      memory-side request, muxed from the granted
//   data_addr_o/wdata_o        master, all zero when nothing is granted
//   data_rdata_i               memory read data, valid the cycle after a read
//
// Handshake: a master raises mX_req_i and holds req and payload stable until
// the cycle in which mX_gnt_o is high; that cycle is the transfer. Exactly one
// cycle later mX_rvalid_o is high for one cycle, for reads and writes alike.
// Grant never depends on anything the master computes from its own grant.
// ----------------------------------------------------------------------------
module miriscv_data_arbiter (
    input  logic        clk_i,
    input  logic        arst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    // Index of the master that wins a tie.
    logic prio_q;
    // A memory response is due this cycle, and which master owns it.
    logic rsp_valid_q;
    logic rsp_id_q;

    logic m0_gnt;
    logic m1_gnt;

    // Grants are gated by reset so no request leaks to memory while the
    // arbiter state is being cleared.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!arst_i) begin
            if (m0_req_i && m1_req_i) begin
                m0_gnt = ~prio_q;
                m1_gnt = prio_q;
            end else begin
                m0_gnt = m0_req_i;
                m1_gnt = m1_req_i;
            end
        end
    end

    assign m0_gnt_o   = m0_gnt;
    assign m1_gnt_o   = m1_gnt;
    assign data_req_o = m0_gnt | m1_gnt;

    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_addr_o  = 32'h0;
        data_wdata_o = 32'h0;
        if (m0_gnt) begin
            data_we_o    = m0_we_i;
            data_be_o    = m0_be_i;
            data_addr_o  = m0_addr_i;
            data_wdata_o = m0_wdata_i;
        end else if (m1_gnt) begin
            data_we_o    = m1_we_i;
            data_be_o    = m1_be_i;
            data_addr_o  = m1_addr_i;
            data_wdata_o = m1_wdata_i;
        end
    end

    // After a grant the loser of that cycle gets the next tie; the tie
    // owner is remembered across idle cycles.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            if (data_req_o) begin
                prio_q <= m0_gnt;
            end
            rsp_valid_q <= data_req_o;
            rsp_id_q    <= m1_gnt;
        end
    end

    assign m0_rvalid_o = rsp_valid_q && !rsp_id_q;
    assign m1_rvalid_o = rsp_valid_q &&  rsp_id_q;

    // Read data only reaches the master that owns the response.
    assign m0_rdata_o = m0_rvalid_o ? data_rdata_i : 32'h0;
    assign m1_rdata_o = m1_rvalid_o ? data_rdata_i : 32'h0;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// ----------------------------------------------------------------------------
// tb_miriscv_data_arbiter
//
// Bench for the two-master data arbiter. A memory device model answers the
// DUT's memory port; a reference model (round-robin winner + its own copy of
// memory) predicts grants and responses and pushes expected responses into
// exp_q; a monitor pops them when rvalid is due.
// ----------------------------------------------------------------------------
module tb_miriscv_data_arbiter;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic arst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        m_req   [2];
    logic        m_we    [2];
    logic [3:0]  m_be    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];

    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [31:0] data_rdata_i = 32'h0;

    miriscv_data_arbiter dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .m0_req_i     (m_req[0]),
        .m0_we_i      (m_we[0]),
        .m0_be_i      (m_be[0]),
        .m0_addr_i    (m_addr[0]),
        .m0_wdata_i   (m_wdata[0]),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (m_req[1]),
        .m1_we_i      (m_we[1]),
        .m1_be_i      (m_be[1]),
        .m1_addr_i    (m_addr[1]),
        .m1_wdata_i   (m_wdata[1]),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .data_req_o   (data_req_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    // {due cycle[65:34], master id[33], is_read[32], read data[31:0]}
    logic [65:0] exp_q[$];

    logic [31:0] mem     [256];   // memory device contents
    logic [31:0] ref_mem [256];   // reference model's view of memory
    logic        ref_prio = 1'b0; // master that wins the next tie
    logic        granted [2];

    // Memory request seen by the device this cycle.
    logic        dev_req;
    logic        dev_we;
    logic [3:0]  dev_be;
    logic [31:0] dev_addr, dev_wdata;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(int m, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_be[m]    = be;
        m_addr[m]  = addr;
        m_wdata[m] = wd;
    endtask

    task automatic new_req(int m);
        set_req(m, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom);
    endtask

    // Negedge: predict the grant, compare the arbiter's outputs, book the
    // expected response and capture what the memory device is asked to do.
    task automatic check_phase(output int win);
        logic [31:0] rd;
        @(negedge clk_i);
        win = -1;
        if (!arst_i) begin
            if (m_req[0] && m_req[1]) win = ref_prio ? 1 : 0;
            else if (m_req[0])        win = 0;
            else if (m_req[1])        win = 1;
        end
        chk("m0_gnt", 32'(m0_gnt_o), 32'(win == 0));
        chk("m1_gnt", 32'(m1_gnt_o), 32'(win == 1));
        chk("data_req", 32'(data_req_o), 32'(win >= 0));
        if (win >= 0) begin
            chk("data_we",    32'(data_we_o),   32'(m_we[win]));
            chk("data_be",    32'(data_be_o),   32'(m_be[win]));
            chk("data_addr",  data_addr_o,      m_addr[win]);
            chk("data_wdata", data_wdata_o,     m_wdata[win]);
            rd = ref_mem[m_addr[win][9:2]];
            if (m_we[win])
                ref_mem[m_addr[win][9:2]] = merge(rd, m_wdata[win], m_be[win]);
            exp_q.push_back({32'(cyc + 1), 1'(win), ~m_we[win], rd});
            ref_prio     = (win == 0);
            granted[win] = 1'b1;
        end else begin
            chk("data_we_idle",    32'(data_we_o), 32'h0);
            chk("data_be_idle",    32'(data_be_o), 32'h0);
            chk("data_addr_idle",  data_addr_o,    32'h0);
            chk("data_wdata_idle", data_wdata_o,   32'h0);
        end
        dev_req   = data_req_o;
        dev_we    = data_we_o;
        dev_be    = data_be_o;
        dev_addr  = data_addr_o;
        dev_wdata = data_wdata_o;
    endtask

    // Posedge: the memory device performs the captured request, and granted
    // masters drop their request.
    task automatic advance();
        @(posedge clk_i);
        #1;
        if (dev_req && dev_we)
            mem[dev_addr[9:2]] = merge(mem[dev_addr[9:2]], dev_wdata, dev_be);
        else if (dev_req)
            data_rdata_i = mem[dev_addr[9:2]];
        else
            data_rdata_i = $urandom;
        for (int m = 0; m < 2; m++) begin
            if (granted[m]) m_req[m] = 1'b0;
            granted[m] = 1'b0;
        end
    endtask

    task automatic step();
        int w;
        check_phase(w);
        advance();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [65:0] e;
        forever begin
            @(negedge clk_i);
            while (exp_q.size() > 0 && int'(exp_q[0][65:34]) < cyc) begin
                e = exp_q.pop_front();
                chk("rsp_missed", 32'(e[65:34]), 32'(cyc));
            end
            if (exp_q.size() > 0 && int'(exp_q[0][65:34]) == cyc) begin
                e = exp_q.pop_front();
                if (e[33] == 1'b0) begin
                    chk("m0_rvalid", 32'(m0_rvalid_o), 32'h1);
                    chk("m1_rvalid_other", 32'(m1_rvalid_o), 32'h0);
                    chk("m1_rdata_other", m1_rdata_o, 32'h0);
                    if (e[32]) chk("m0_rdata", m0_rdata_o, e[31:0]);
                end else begin
                    chk("m1_rvalid", 32'(m1_rvalid_o), 32'h1);
                    chk("m0_rvalid_other", 32'(m0_rvalid_o), 32'h0);
                    chk("m0_rdata_other", m0_rdata_o, 32'h0);
                    if (e[32]) chk("m1_rdata", m1_rdata_o, e[31:0]);
                end
            end else begin
                chk("m0_rvalid_idle", 32'(m0_rvalid_o), 32'h0);
                chk("m1_rvalid_idle", 32'(m1_rvalid_o), 32'h0);
                chk("m0_rdata_idle", m0_rdata_o, 32'h0);
                chk("m1_rdata_idle", m1_rdata_o, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int wins[$];

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int m = 0; m < 2; m++) begin
            set_req(m, 1'b0, 4'h0, 32'h0, 32'h0);
            m_req[m]   = 1'b0;
            granted[m] = 1'b0;
        end

        // Reset with both masters requesting: everything quiet.
        #1 arst_i = 1'b1;
        new_req(0);
        new_req(1);
        check_phase(w);
        advance();
        check_phase(w);
        advance();
        arst_i   = 1'b0;
        ref_prio = 1'b0;

        // First contended grant after release goes to master 0.
        check_phase(w);
        chk("first_after_reset", 32'(w), 32'h0);
        advance();
        step();               // m1 still pending, gets its turn
        step();               // drain

        // Single read from master 0.
        mem[64]     = 32'hDEADBEEF;
        ref_mem[64] = 32'hDEADBEEF;
        set_req(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
        step();
        step();

        // Contention: both masters request continuously for 6 cycles.
        new_req(0);
        new_req(1);
        for (int i = 0; i < 6; i++) begin
            check_phase(w);
            wins.push_back(w);
            advance();
            for (int m = 0; m < 2; m++)
                if (!m_req[m]) new_req(m);
        end
        for (int i = 1; i < 6; i++)
            chk("alternate", 32'(wins[i]), 32'(1 - wins[i-1]));
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        step();
        step();

        // Write acknowledge from master 1.
        set_req(1, 1'b1, 4'h3, 32'h0000_0020, 32'h1234_5678);
        step();
        step();
        // Read back the partially written word through master 0.
        set_req(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        step();
        step();

        // Priority retention: m1 alone, 3 idle cycles, then a tie -> m0.
        set_req(1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
        step();
        step();
        step();
        step();
        new_req(0);
        new_req(1);
        check_phase(w);
        chk("prio_retained", 32'(w), 32'h0);
        advance();
        step();
        step();

        // Reset mid-op: granted read never gets its rvalid.
        m_req[1] = 1'b0;
        set_req(0, 1'b0, 4'hF, 32'h0000_0080, 32'h0);
        check_phase(w);
        #2 arst_i = 1'b1;
        exp_q.delete();
        ref_prio = 1'b0;
        m_req[0] = 1'b0;
        advance();
        arst_i = 1'b0;
        step();               // monitor requires no rvalid here
        new_req(0);
        new_req(1);
        check_phase(w);
        chk("prio_after_reset", 32'(w), 32'h0);
        advance();
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++)
                if (!m_req[m] && $urandom_range(0, 9) < 6) new_req(m);
            step();
        end
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        step();
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
